instr_decode: RTL and testbench

Registered instruction decoder for the 16-bit RISC core. It sits directly upstream of reg_file and drives that block's selA/selB/selD/we from each fetched instruction. It also drives ALU op/immediate controls. A valid/ready input handshake, a downstream stall input and a one-entry skid buffer let fetch and execute stall independently. A 1-cycle decode latency applies when the pipeline is not stalled.

---
 rtl/instr_decode.sv | 114 +++++++++++
 tb/tb_instr_decode.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode.sv
// Registered instruction decoder for the 16-bit RISC core.
// Fetch-side valid/ready handshake, a downstream stall, and a one-entry skid
// buffer let fetch and execute stall independently without losing or
// duplicating an instruction. Decoded fields come straight from the output
// register; write-enable and illegal flags are decoded when it loads.
module instr_decode #(
    parameter int COUNT_W   = 16,
    parameter int REG_SEL_W = 3
) (
    input  logic                 I_clk,
    input  logic                 I_rst,
    input  logic                 I_en,
    input  logic                 I_flush,
    input  logic                 I_valid,
    input  logic [15:0]          I_instr,
    output logic                 O_ready,
    input  logic                 I_stall,
    output logic                 O_valid,
    output logic [3:0]           O_aluop,
    output logic [REG_SEL_W-1:0] O_selD,
    output logic [REG_SEL_W-1:0] O_selA,
    output logic [REG_SEL_W-1:0] O_selB,
    output logic                 O_immsel,
    output logic [7:0]           O_imm,
    output logic                 O_regwe,
    output logic                 O_illegal,
    output logic [COUNT_W-1:0]   O_count
);

    // Every legal opcode writes a register except WRITE, JUMP and JUMPEQ.
    function automatic logic decodeRegWe(input logic [3:0] op);
        return (op <= 4'hB) && (op != 4'h7);
    endfunction

    // Opcodes 0xE and 0xF are unassigned.
    function automatic logic decodeIllegal(input logic [3:0] op);
        return op >= 4'hE;
    endfunction

    logic [15:0]        skidInstr_p0;
    logic               skidFull_p0;
    logic [15:0]        outInstr_p1;
    logic               vld_p1;
    logic               regwe_p1;
    logic               illegal_p1;
    logic [COUNT_W-1:0] countQ;

    logic               readyC;
    logic               acceptC;
    logic               handoffC;
    logic               outAdvanceC;
    logic [15:0]        srcInstrC;

    // Handshake qualifiers; the skid entry is older than anything on the input.
    always_comb begin
        readyC      = I_en & ~skidFull_p0 & ~I_flush;
        acceptC     = I_valid & readyC;
        handoffC    = vld_p1 & ~I_stall & I_en & ~I_flush;
        outAdvanceC = ~vld_p1 | ~I_stall;
        srcInstrC   = skidFull_p0 ? skidInstr_p0 : I_instr;
    end

    // Output register, skid buffer and issue counter; flush beats everything.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            skidInstr_p0 <= '0;
            skidFull_p0  <= 1'b0;
            outInstr_p1  <= '0;
            vld_p1       <= 1'b0;
            regwe_p1     <= 1'b0;
            illegal_p1   <= 1'b0;
            countQ       <= '0;
        end else if (I_en) begin
            if (I_flush) begin
                vld_p1      <= 1'b0;
                skidFull_p0 <= 1'b0;
            end else begin
                if (outAdvanceC) begin
                    if (skidFull_p0 || acceptC) begin
                        outInstr_p1 <= srcInstrC;
                        regwe_p1    <= decodeRegWe(srcInstrC[15:12]);
                        illegal_p1  <= decodeIllegal(srcInstrC[15:12]);
                        vld_p1      <= 1'b1;
                        skidFull_p0 <= 1'b0;
                    end else begin
                        vld_p1 <= 1'b0;
                    end
                end else if (acceptC) begin
                    skidInstr_p0 <= I_instr;
                    skidFull_p0  <= 1'b1;
                end
                if (handoffC) begin
                    countQ <= countQ + COUNT_W'(1);
                end
            end
        end
    end

    // Field extraction; control flags are gated by valid.
    always_comb begin
        O_ready   = readyC;
        O_valid   = vld_p1;
        O_aluop   = outInstr_p1[15:12];
        O_selD    = outInstr_p1[11:9];
        O_immsel  = outInstr_p1[8];
        O_selA    = outInstr_p1[7:5];
        O_selB    = outInstr_p1[4:2];
        O_imm     = outInstr_p1[7:0];
        O_regwe   = vld_p1 & regwe_p1;
        O_illegal = vld_p1 & illegal_p1;
        O_count   = countQ;
    end

endmodule

// File: tb/tb_instr_decode.sv
// Directed testbench for instr_decode: streaming, stall/skid ordering, decode
// flags, flush, enable freeze, async reset and counter wrap.
module tb_instr_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        flush;
    logic        valid;
    logic [15:0] instr;
    logic        stall;

    logic        ready;
    logic        oValid;
    logic [3:0]  aluop;
    logic [2:0]  selD;
    logic [2:0]  selA;
    logic [2:0]  selB;
    logic        immsel;
    logic [7:0]  imm;
    logic        regwe;
    logic        illegal;
    logic [15:0] count;

    logic        ready4;
    logic        oValid4;
    logic [3:0]  aluop4;
    logic [2:0]  selD4;
    logic [2:0]  selA4;
    logic [2:0]  selB4;
    logic        immsel4;
    logic [7:0]  imm4;
    logic        regwe4;
    logic        illegal4;
    logic [3:0]  count4;

    int nTests = 0;
    int nFail  = 0;

    logic [15:0] word;
    assign word = {aluop, selD, immsel, imm};

    always #5 clk = ~clk;

    instr_decode #(.COUNT_W(16)) dut (
        .I_clk(clk), .I_rst(rst), .I_en(en), .I_flush(flush),
        .I_valid(valid), .I_instr(instr), .O_ready(ready), .I_stall(stall),
        .O_valid(oValid), .O_aluop(aluop), .O_selD(selD), .O_selA(selA),
        .O_selB(selB), .O_immsel(immsel), .O_imm(imm), .O_regwe(regwe),
        .O_illegal(illegal), .O_count(count)
    );

    instr_decode #(.COUNT_W(4)) dut4 (
        .I_clk(clk), .I_rst(rst), .I_en(en), .I_flush(flush),
        .I_valid(valid), .I_instr(instr), .O_ready(ready4), .I_stall(stall),
        .O_valid(oValid4), .O_aluop(aluop4), .O_selD(selD4), .O_selA(selA4),
        .O_selB(selB4), .O_immsel(immsel4), .O_imm(imm4), .O_regwe(regwe4),
        .O_illegal(illegal4), .O_count(count4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; flush = 1'b0; valid = 1'b0; instr = 16'h0; stall = 1'b0;
        step(); step();
        nTests++;
        if (oValid !== 1'b0 || regwe !== 1'b0 || illegal !== 1'b0) begin
            nFail++; $display("FAIL reset_ctrl: valid=%b regwe=%b illegal=%b, want 0 0 0", oValid, regwe, illegal);
        end
        nTests++;
        if (count !== 16'd0 || word !== 16'h0 || selA !== 3'd0 || selB !== 3'd0) begin
            nFail++; $display("FAIL reset_data: count=%0d word=%h selA=%0d selB=%0d, want all 0", count, word, selA, selB);
        end
        rst = 1'b0;
        #1;
        nTests++;
        if (ready !== 1'b1) begin
            nFail++; $display("FAIL reset_ready: ready=%b, want 1", ready);
        end
    endtask

    task automatic test_stream();
        valid = 1'b1; instr = 16'h0A24;
        step();
        nTests++;
        if (oValid !== 1'b1 || aluop !== 4'd0 || selD !== 3'd5 || selA !== 3'd1 || selB !== 3'd1 || regwe !== 1'b1) begin
            nFail++; $display("FAIL stream_add: v=%b op=%0d D=%0d A=%0d B=%0d we=%b, want 1 0 5 1 1 1",
                              oValid, aluop, selD, selA, selB, regwe);
        end
        instr = 16'h7000;
        step();
        nTests++;
        if (oValid !== 1'b1 || aluop !== 4'd7 || regwe !== 1'b0) begin
            nFail++; $display("FAIL stream_write: v=%b op=%0d we=%b, want 1 7 0", oValid, aluop, regwe);
        end
        valid = 1'b0;
        step();
        nTests++;
        if (count !== 16'd2 || oValid !== 1'b0) begin
            nFail++; $display("FAIL stream_count: count=%0d valid=%b, want 2 0", count, oValid);
        end
    endtask

    task automatic test_back_to_back();
        stall = 1'b1; valid = 1'b1; instr = 16'h1111;
        step();
        instr = 16'h2222;
        step();
        instr = 16'h3333;
        step();
        nTests++;
        if (word !== 16'h1111 || oValid !== 1'b1 || ready !== 1'b0 || count !== 16'd2) begin
            nFail++; $display("FAIL stall_hold: word=%h valid=%b ready=%b count=%0d, want 1111 1 0 2",
                              word, oValid, ready, count);
        end
        stall = 1'b0;
        step();
        nTests++;
        if (word !== 16'h2222 || oValid !== 1'b1) begin
            nFail++; $display("FAIL skid_drain: word=%h valid=%b, want 2222 1", word, oValid);
        end
        step();
        valid = 1'b0;
        nTests++;
        if (word !== 16'h3333 || oValid !== 1'b1) begin
            nFail++; $display("FAIL after_skid: word=%h valid=%b, want 3333 1", word, oValid);
        end
        step();
        nTests++;
        if (count !== 16'd5 || oValid !== 1'b0) begin
            nFail++; $display("FAIL stall_count: count=%0d valid=%b, want 5 0", count, oValid);
        end
    endtask

    task automatic test_illegal();
        valid = 1'b1; instr = 16'hF123;
        step();
        nTests++;
        if (illegal !== 1'b1 || regwe !== 1'b0 || oValid !== 1'b1 || word !== 16'hF123) begin
            nFail++; $display("FAIL illegal_f: ill=%b we=%b v=%b word=%h, want 1 0 1 f123", illegal, regwe, oValid, word);
        end
        instr = 16'h8000;
        step();
        nTests++;
        if (illegal !== 1'b0 || regwe !== 1'b1) begin
            nFail++; $display("FAIL legal_load: ill=%b we=%b, want 0 1", illegal, regwe);
        end
        instr = 16'hC000;
        step();
        valid = 1'b0;
        nTests++;
        if (illegal !== 1'b0 || regwe !== 1'b0 || aluop !== 4'hC) begin
            nFail++; $display("FAIL jump: ill=%b we=%b op=%h, want 0 0 c", illegal, regwe, aluop);
        end
        step();
        nTests++;
        if (regwe !== 1'b0 || illegal !== 1'b0 || count !== 16'd8) begin
            nFail++; $display("FAIL idle_gate: we=%b ill=%b count=%0d, want 0 0 8", regwe, illegal, count);
        end
    endtask

    task automatic test_flush();
        stall = 1'b1; valid = 1'b1; instr = 16'h1234;
        step();
        instr = 16'h5678;
        step();
        nTests++;
        if (ready !== 1'b0) begin
            nFail++; $display("FAIL flush_setup: ready=%b, want 0", ready);
        end
        flush = 1'b1; instr = 16'h9ABC; stall = 1'b0;
        step();
        flush = 1'b0; valid = 1'b0;
        #1;
        nTests++;
        if (oValid !== 1'b0 || ready !== 1'b1 || count !== 16'd8) begin
            nFail++; $display("FAIL flush: valid=%b ready=%b count=%0d, want 0 1 8", oValid, ready, count);
        end
        step();
        nTests++;
        if (oValid !== 1'b0 || count !== 16'd8) begin
            nFail++; $display("FAIL flush_skid_empty: valid=%b count=%0d, want 0 8", oValid, count);
        end
    endtask

    task automatic test_enable();
        valid = 1'b1; instr = 16'h2468;
        step();
        instr = 16'h3579; en = 1'b0;
        #1;
        nTests++;
        if (ready !== 1'b0) begin
            nFail++; $display("FAIL en_ready: ready=%b, want 0", ready);
        end
        for (int i = 0; i < 3; i++) begin
            step();
        end
        nTests++;
        if (word !== 16'h2468 || oValid !== 1'b1 || count !== 16'd8) begin
            nFail++; $display("FAIL en_freeze: word=%h valid=%b count=%0d, want 2468 1 8", word, oValid, count);
        end
        en = 1'b1;
        step();
        valid = 1'b0;
        nTests++;
        if (word !== 16'h3579 || oValid !== 1'b1 || count !== 16'd9) begin
            nFail++; $display("FAIL en_resume: word=%h valid=%b count=%0d, want 3579 1 9", word, oValid, count);
        end
        step();
        nTests++;
        if (count !== 16'd10 || oValid !== 1'b0) begin
            nFail++; $display("FAIL en_drain: count=%0d valid=%b, want 10 0", count, oValid);
        end
    endtask

    task automatic test_async_reset();
        stall = 1'b1; valid = 1'b1; instr = 16'h1111;
        step();
        instr = 16'h2222;
        step();
        #2;
        rst = 1'b1;
        #1;
        nTests++;
        if (oValid !== 1'b0 || count !== 16'd0 || word !== 16'h0) begin
            nFail++; $display("FAIL async_reset: valid=%b count=%0d word=%h, want 0 0 0000", oValid, count, word);
        end
        valid = 1'b0; stall = 1'b0;
        step();
        rst = 1'b0;
        step();
        nTests++;
        if (oValid !== 1'b0 || ready !== 1'b1) begin
            nFail++; $display("FAIL reset_skid_clear: valid=%b ready=%b, want 0 1", oValid, ready);
        end
    endtask

    task automatic test_wrap();
        valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            instr = 16'(i);
            step();
        end
        valid = 1'b0;
        step();
        nTests++;
        if (count4 !== 4'd1 || count !== 16'd17) begin
            nFail++; $display("FAIL count_wrap: count4=%0d count=%0d, want 1 17", count4, count);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_enable();
        test_async_reset();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
